piso_serializer: RTL

Parallel-in serial-out transmitter, the counterpart of the team's parallel load register.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per accepted cycle on a serial valid/ready link.
- Flags the final bit of each word with ser_last.
- Sits between a parallel data source (register bank or FSM) and any bit-serial consumer such as a SIPO receiver or a line driver.

---
 rtl/piso_pkg.sv | 20 ++
 rtl/piso_shift_core.sv | 36 +++
 rtl/piso_serializer.sv | 80 ++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Loadable shift register; shifts toward the output tap with zero fill.
module piso_shift_core
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_bit
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_data;
    end else if (shift_en) begin
      if (LSB_FIRST) shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      else           shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) shreg_q <= '0;
    else        shreg_q <= shreg_d;
  end

  assign out_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready on both sides and a
// last-bit flag; back-to-back words stream without a bubble.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned           CW      = clog2(WIDTH);
  localparam logic [CW-1:0]         CNT_MAX = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          load, shift_en, core_bit;
  logic          accept, xfer, cnt_zero;

  assign busy      = (state_q == ST_SHIFT);
  assign ser_valid = busy;
  assign cnt_zero  = (count_q == '0);
  assign ser_last  = ser_valid & cnt_zero;
  assign in_ready  = ~busy | (cnt_zero & ser_ready);
  assign accept    = in_valid & in_ready;
  assign xfer      = ser_valid & ser_ready;
  // The core keeps the final bit after the word ends, so gate it off here.
  assign ser_out   = ser_valid & core_bit;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load     = 1'b0;
    shift_en = 1'b0;
    if (accept) begin
      load    = 1'b1;
      count_d = CNT_MAX;
      state_d = ST_SHIFT;
    end else if (xfer) begin
      if (!cnt_zero) begin
        shift_en = 1'b1;
        count_d  = count_q - CW'(1);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .shift_en  (shift_en),
    .load_data (in_data),
    .out_bit   (core_bit)
  );

endmodule
